lu32_arbiter: RTL and testbench

LU32_ARBITER -- requirements
Module: lu32_arbiter

---
 rtl/lu32_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_lu32_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lu32_arbiter.sv
// Two-requester round-robin arbiter in front of one shared 32-bit logic unit.
// Optional grant counters are built only when LU32_GNT_CNT_EN is defined.

module lu32_inv (
    input  logic [31:0] a,
    output logic [31:0] y
);
    assign y = ~a;
endmodule

module lu32_and (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a & b;
endmodule

module lu32_or (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a | b;
endmodule

module lu32_xor (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a ^ b;
endmodule

module lu32_xnor (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = ~(a ^ b);
endmodule

// Shared logic unit: every op result is built from the gate primitives, op selects one.
module lu32_logic_unit (
    input  logic [2:0]  op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] result
);
    logic [31:0] inv_x, and_xy, or_xy, xor_xy, xnor_xy, nand_xy, nor_xy;

    lu32_inv  u_inv_x   (.a(x),      .y(inv_x));
    lu32_and  u_and     (.a(x),      .b(y), .y(and_xy));
    lu32_or   u_or      (.a(x),      .b(y), .y(or_xy));
    lu32_xor  u_xor     (.a(x),      .b(y), .y(xor_xy));
    lu32_xnor u_xnor    (.a(x),      .b(y), .y(xnor_xy));
    lu32_inv  u_inv_and (.a(and_xy), .y(nand_xy));
    lu32_inv  u_inv_or  (.a(or_xy),  .y(nor_xy));

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        result = x;
        case (op)
            3'b000:  result = inv_x;
            3'b001:  result = and_xy;
            3'b010:  result = or_xy;
            3'b011:  result = xor_xy;
            3'b100:  result = xnor_xy;
            3'b101:  result = nand_xy;
            3'b110:  result = nor_xy;
            default: result = x;
        endcase
    end
endmodule

module lu32_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_op,
    input  logic [31:0] a_x,
    input  logic [31:0] a_y,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [2:0]  b_op,
    input  logic [31:0] b_x,
    input  logic [31:0] b_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
`ifdef LU32_GNT_CNT_EN
    output logic [7:0]  a_gnt_cnt,
    output logic [7:0]  b_gnt_cnt,
`endif
    output logic [31:0] rsp_data
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_gnt_b;
    logic        grant_a;
    logic        grant_b;
    logic        accept;
    logic [2:0]  cap_op;
    logic [31:0] cap_x;
    logic [31:0] cap_y;
    logic        cap_id;
    logic [31:0] lu_result;

    // On a tie the requester that was not granted last wins; a lone requester always wins.
    assign grant_a = a_valid & (~b_valid | last_gnt_b);
    assign grant_b = b_valid & (~a_valid | ~last_gnt_b);
    assign accept  = a_ready | b_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (a_valid | b_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Readies are masked by reset so nothing is accepted in a reset cycle.
    always_comb begin
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                a_ready = ~reset & grant_a;
                b_ready = ~reset & grant_b;
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)       last_gnt_b <= 1'b1;
        else if (accept) last_gnt_b <= b_ready;
    end

    // NOTE: the capture registers carry no reset; they are always written before being consumed.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_op <= b_ready ? b_op : a_op;
            cap_x  <= b_ready ? b_x  : a_x;
            cap_y  <= b_ready ? b_y  : a_y;
            cap_id <= b_ready;
        end
    end

    lu32_logic_unit u_lu (
        .op     (cap_op),
        .x      (cap_x),
        .y      (cap_y),
        .result (lu_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_data <= 32'd0;
            rsp_id   <= 1'b0;
        end else if (state == EXEC) begin
            rsp_data <= lu_result;
            rsp_id   <= cap_id;
        end
    end

`ifdef LU32_GNT_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            a_gnt_cnt <= 8'd0;
            b_gnt_cnt <= 8'd0;
        end else begin
            if (a_ready && a_gnt_cnt != 8'hFF) a_gnt_cnt <= a_gnt_cnt + 8'd1;
            if (b_ready && b_gnt_cnt != 8'hFF) b_gnt_cnt <= b_gnt_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lu32_arbiter.sv
// Bench for lu32_arbiter: vector table plus hand-written multi-cycle sequences,
// responses checked through a scoreboard queue. Define LU32_GNT_CNT_EN to cover the counters.

module tb_lu32_arbiter;
    logic        clk;
    logic        reset;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [2:0]  a_op, b_op;
    logic [31:0] a_x, a_y, b_x, b_y;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;
`ifdef LU32_GNT_CNT_EN
    logic [7:0]  a_gnt_cnt, b_gnt_cnt;
`endif

    lu32_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_op      (a_op),
        .a_x       (a_x),
        .a_y       (a_y),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_op      (b_op),
        .b_x       (b_x),
        .b_y       (b_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
`ifdef LU32_GNT_CNT_EN
        .a_gnt_cnt (a_gnt_cnt),
        .b_gnt_cnt (b_gnt_cnt),
`endif
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic        bv;
        logic [2:0]  aop;
        logic [31:0] ax;
        logic [31:0] ay;
        logic [2:0]  bop;
        logic [31:0] bx;
        logic [31:0] by;
        logic        exp_a;
        logic        exp_b;
        logic        exp_id;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs[11];
    logic [32:0] sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every handshaken response must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got id=%0d data=%h expected no response", rsp_id, rsp_data);
            end else begin
                check("rsp_id_data", {rsp_id, rsp_data}, sb.pop_front());
            end
        end
    end

    // Starts at posedge+1 with the DUT idle; leaves at posedge+1 with the DUT idle again.
    task automatic apply(input vec_t v);
        a_valid = v.av;  a_op = v.aop; a_x = v.ax; a_y = v.ay;
        b_valid = v.bv;  b_op = v.bop; b_x = v.bx; b_y = v.by;
        @(negedge clk);
        check("a_ready", a_ready, v.exp_a);
        check("b_ready", b_ready, v.exp_b);
        if (v.exp_a || v.exp_b) sb.push_back({v.exp_id, v.exp_data});
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_x = $urandom; a_y = $urandom; b_x = $urandom; b_y = $urandom;
        a_op = 3'($urandom); b_op = 3'($urandom);
        @(negedge clk);
        check("rsp_valid_n1", rsp_valid, 1'b0);
        if (v.exp_a || v.exp_b) begin
            check("busy_readies", {a_ready, b_ready}, 2'b00);
            @(negedge clk);
            check("rsp_valid_n2", rsp_valid, 1'b1);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_ready(output logic got_a, output logic got_b);
        got_a = 1'b0;
        got_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_ready || b_ready) begin
                got_a = a_ready;
                got_b = b_ready;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_ready: got no ready expected one within 10 cycles");
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        v;
        logic        ga, gb;
        logic [32:0] exp_seq[4];

        //             av    bv    aop     ax            ay            bop     bx            by            ea    eb    id    data
        vecs[0]  = '{1'b1, 1'b0, 3'b001, 32'hFFFF0000, 32'h0F0F0F0F, 3'b000, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h0F0F0000};
        vecs[1]  = '{1'b0, 1'b1, 3'b001, 32'h0,        32'h0,        3'b000, 32'h00000000, 32'h0,        1'b0, 1'b1, 1'b1, 32'hFFFFFFFF};
        vecs[2]  = '{1'b1, 1'b1, 3'b010, 32'h12340000, 32'h00005678, 3'b011, 32'h1,        32'h2,        1'b1, 1'b0, 1'b0, 32'h12345678};
        vecs[3]  = '{1'b1, 1'b1, 3'b111, 32'h11112222, 32'h0,        3'b011, 32'hAAAA5555, 32'hFFFF0000, 1'b0, 1'b1, 1'b1, 32'h55555555};
        vecs[4]  = '{1'b1, 1'b0, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'hF00FF00F};
        vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'hFFFFFFFF, 32'h0000FFFF, 3'b000, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'hFFFF0000};
        vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h0,        32'h0,        3'b110, 32'h00FF00FF, 32'h0F0F0000, 1'b0, 1'b1, 1'b1, 32'hF000FF00};
        vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h0,        32'h0,        3'b111, 32'hDEADBEEF, 32'h12345678, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF};
        vecs[8]  = '{1'b1, 1'b1, 3'b000, 32'h13579BDF, 32'hFFFFFFFF, 3'b111, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'hECA86420};
        vecs[9]  = '{1'b0, 1'b0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 3'b010, 32'h1,        32'h2,        3'b001, 32'h89ABCDEF, 32'hF0F0F0F0, 1'b0, 1'b1, 1'b1, 32'h80A0C0E0};

        reset = 1'b1; rsp_ready = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_op = 3'b0; b_op = 3'b0; a_x = 32'h0; a_y = 32'h0; b_x = 32'h0; b_y = 32'h0;

        // Reset state, with a request present during reset.
        repeat (2) @(posedge clk);
        #1 a_valid = 1'b1;
        @(negedge clk);
        check("reset_readies", {a_ready, b_ready}, 2'b00);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_id_data", {rsp_id, rsp_data}, 33'd0);
        @(posedge clk); #1;
        reset = 1'b0; a_valid = 1'b0;

        for (int i = 0; i < 11; i++) apply(vecs[i]);

        // Persistent tie after reset: grants alternate A, B, A, B.
        pulse_reset();
        a_valid = 1'b1; a_op = 3'b001; a_x = 32'h0000FFFF; a_y = 32'h00FF00FF;
        b_valid = 1'b1; b_op = 3'b010; b_x = 32'hF0000000; b_y = 32'h0000000F;
        exp_seq[0] = {1'b0, 32'h000000FF};
        exp_seq[1] = {1'b1, 32'hF000000F};
        exp_seq[2] = {1'b0, 32'h000000FF};
        exp_seq[3] = {1'b1, 32'hF000000F};
        for (int k = 0; k < 4; k++) begin
            wait_ready(ga, gb);
            check("rr_grant", {ga, gb}, (k % 2 == 0) ? 2'b10 : 2'b01);
            sb.push_back(exp_seq[k]);
        end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Back-pressure: result held for 5 cycles while inputs churn.
        rsp_ready = 1'b0;
        a_valid = 1'b1; a_op = 3'b011; a_x = 32'hFFFFFFFF; a_y = 32'h12345678;
        @(negedge clk);
        check("bp_a_ready", {a_ready, b_ready}, 2'b10);
        sb.push_back({1'b0, 32'hEDCBA987});
        @(posedge clk); #1;
        b_valid = 1'b1;
        a_x = $urandom; b_x = $urandom;
        @(negedge clk);
        check("bp_exec_rsp_valid", rsp_valid, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold", {rsp_valid, a_ready, b_ready, rsp_id, rsp_data}, {4'b1000, 32'hEDCBA987});
            @(posedge clk); #1;
            a_x = $urandom; a_y = $urandom; b_x = $urandom; b_y = $urandom;
            a_op = 3'($urandom); b_op = 3'($urandom);
        end
        rsp_ready = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;

        // Reset in EXEC drops the pending result; the next tie goes to A.
        a_valid = 1'b1; a_op = 3'b111; a_x = 32'h11111111;
        @(negedge clk);
        check("rx_a_ready", {a_ready, b_ready}, 2'b10);
        @(posedge clk); #1;
        a_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rx_rsp_valid", rsp_valid, 1'b0);
        check("rx_rsp_data", {rsp_id, rsp_data}, 33'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rx_rsp_valid_later", rsp_valid, 1'b0);
        @(posedge clk); #1;
        v = '{1'b1, 1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000AAAA, 3'b111, 32'h5, 32'h0,
              1'b1, 1'b0, 1'b0, 32'h0000AAAA};
        apply(v);

`ifdef LU32_GNT_CNT_EN
        // Grant counters saturate at 255.
        pulse_reset();
        @(negedge clk);
        check("cnt_reset", {a_gnt_cnt, b_gnt_cnt}, 16'h0000);
        @(posedge clk); #1;
        for (int i = 0; i < 300; i++) begin
            v = '{1'b1, 1'b0, 3'b111, 32'(i), 32'h0, 3'b000, 32'h0, 32'h0,
                  1'b1, 1'b0, 1'b0, 32'(i)};
            apply(v);
        end
        @(negedge clk);
        check("a_gnt_cnt_sat", a_gnt_cnt, 8'd255);
        check("b_gnt_cnt", b_gnt_cnt, 8'd0);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        check("sb_empty", 33'(sb.size()), 33'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
